// File: rtl/df_tile_sequencer.sv
// rtl/df_tile_sequencer.sv - SAURIA tile loop-nest sequencer (k,y,x,c) emitting psums/ifmaps/weights offsets; optional DF_TILE_SEQ_STALL_CNT_EN adds o_stall_cnt
module df_tile_sequencer #(
  parameter int OFFS_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [11:0]       i_x_lim,
  input  logic [11:0]       i_y_lim,
  input  logic [11:0]       i_k_lim,
  input  logic [11:0]       i_c_lim,
  input  logic [11:0]       i_ps_xs,
  input  logic [23:0]       i_ps_ys,
  input  logic [23:0]       i_ps_ks,
  input  logic [11:0]       i_if_xs,
  input  logic [23:0]       i_if_ys,
  input  logic [23:0]       i_if_cs,
  input  logic [19:0]       i_wt_ks,
  input  logic [15:0]       i_wt_cs,
  output logic              o_tile_valid,
  input  logic              i_tile_ready,
  output logic [OFFS_W-1:0] o_ps_offs,
  output logic [OFFS_W-1:0] o_if_offs,
  output logic [OFFS_W-1:0] o_wt_offs,
  output logic              o_first_c,
  output logic              o_last_c,
  output logic              o_last_tile,
  output logic              o_busy,
`ifdef DF_TILE_SEQ_STALL_CNT_EN
  output logic [31:0]       o_stall_cnt,
`endif
  output logic              o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  // Latched layer configuration
  logic [11:0] x_lim_q, y_lim_q, k_lim_q, c_lim_q;
  logic [11:0] ps_xs_q, if_xs_q;
  logic [23:0] ps_ys_q, ps_ks_q, if_ys_q, if_cs_q;
  logic [19:0] wt_ks_q;
  logic [15:0] wt_cs_q;

  // Loop counters
  logic [11:0] x_q, y_q, k_q, c_q;

  // Per-level base registers; *_q without a level suffix is the emitted offset
  logic [OFFS_W-1:0] ps_kb_q, ps_yb_q, ps_q;
  logic [OFFS_W-1:0] if_yb_q, if_xb_q, if_q;
  logic [OFFS_W-1:0] wt_kb_q, wt_q;

  logic run, accept, last_tile, start_ok;
  logic [OFFS_W-1:0] ps_xs_e, ps_ys_e, ps_ks_e, if_xs_e, if_ys_e, if_cs_e, wt_ks_e, wt_cs_e;
  logic [OFFS_W-1:0] ps_kb_nx, ps_yb_nx, if_yb_nx, if_xb_nx, wt_kb_nx;

  assign run       = (state_q == S_RUN);
  assign accept    = run && i_tile_ready;
  assign start_ok  = (state_q == S_IDLE) && i_start;
  assign last_tile = (c_q == c_lim_q) && (x_q == x_lim_q) && (y_q == y_lim_q) && (k_q == k_lim_q);

  assign ps_xs_e = OFFS_W'(ps_xs_q);
  assign ps_ys_e = OFFS_W'(ps_ys_q);
  assign ps_ks_e = OFFS_W'(ps_ks_q);
  assign if_xs_e = OFFS_W'(if_xs_q);
  assign if_ys_e = OFFS_W'(if_ys_q);
  assign if_cs_e = OFFS_W'(if_cs_q);
  assign wt_ks_e = OFFS_W'(wt_ks_q);
  assign wt_cs_e = OFFS_W'(wt_cs_q);

  assign ps_kb_nx = ps_kb_q + ps_ks_e;
  assign ps_yb_nx = ps_yb_q + ps_ys_e;
  assign if_yb_nx = if_yb_q + if_ys_e;
  assign if_xb_nx = if_xb_q + if_xs_e;
  assign wt_kb_nx = wt_kb_q + wt_ks_e;

  assign o_tile_valid = run;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);
  assign o_first_c    = run && (c_q == 12'd0);
  assign o_last_c     = run && (c_q == c_lim_q);
  assign o_last_tile  = run && last_tile;
  assign o_ps_offs    = ps_q;
  assign o_if_offs    = if_q;
  assign o_wt_offs    = wt_q;

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: one start launches a layer; DONE is a single-cycle epilogue
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_RUN;
      S_RUN:   if (accept && last_tile) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Config latch, loop counters and incremental offsets; wraps reload from the outer base
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      x_lim_q <= '0; y_lim_q <= '0; k_lim_q <= '0; c_lim_q <= '0;
      ps_xs_q <= '0; ps_ys_q <= '0; ps_ks_q <= '0;
      if_xs_q <= '0; if_ys_q <= '0; if_cs_q <= '0;
      wt_ks_q <= '0; wt_cs_q <= '0;
      x_q <= '0; y_q <= '0; k_q <= '0; c_q <= '0;
      ps_kb_q <= '0; ps_yb_q <= '0; ps_q <= '0;
      if_yb_q <= '0; if_xb_q <= '0; if_q <= '0;
      wt_kb_q <= '0; wt_q <= '0;
    end else if (start_ok) begin
      x_lim_q <= i_x_lim; y_lim_q <= i_y_lim; k_lim_q <= i_k_lim; c_lim_q <= i_c_lim;
      ps_xs_q <= i_ps_xs; ps_ys_q <= i_ps_ys; ps_ks_q <= i_ps_ks;
      if_xs_q <= i_if_xs; if_ys_q <= i_if_ys; if_cs_q <= i_if_cs;
      wt_ks_q <= i_wt_ks; wt_cs_q <= i_wt_cs;
      x_q <= '0; y_q <= '0; k_q <= '0; c_q <= '0;
      ps_kb_q <= '0; ps_yb_q <= '0; ps_q <= '0;
      if_yb_q <= '0; if_xb_q <= '0; if_q <= '0;
      wt_kb_q <= '0; wt_q <= '0;
    end else if (accept && !last_tile) begin
      if (c_q != c_lim_q) begin
        c_q  <= c_q + 12'd1;
        if_q <= if_q + if_cs_e;
        wt_q <= wt_q + wt_cs_e;
      end else begin
        c_q <= '0;
        if (x_q != x_lim_q) begin
          x_q     <= x_q + 12'd1;
          ps_q    <= ps_q + ps_xs_e;
          if_xb_q <= if_xb_nx;
          if_q    <= if_xb_nx;
          wt_q    <= wt_kb_q;
        end else begin
          x_q <= '0;
          if (y_q != y_lim_q) begin
            y_q     <= y_q + 12'd1;
            ps_yb_q <= ps_yb_nx;
            ps_q    <= ps_yb_nx;
            if_yb_q <= if_yb_nx;
            if_xb_q <= if_yb_nx;
            if_q    <= if_yb_nx;
            wt_q    <= wt_kb_q;
          end else begin
            y_q     <= '0;
            k_q     <= k_q + 12'd1;
            ps_kb_q <= ps_kb_nx;
            ps_yb_q <= ps_kb_nx;
            ps_q    <= ps_kb_nx;
            if_yb_q <= '0;
            if_xb_q <= '0;
            if_q    <= '0;
            wt_kb_q <= wt_kb_nx;
            wt_q    <= wt_kb_nx;
          end
        end
      end
    end
  end

`ifdef DF_TILE_SEQ_STALL_CNT_EN
  // Saturating count of back-pressured descriptor cycles for the current layer
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                                 o_stall_cnt <= '0;
    else if (start_ok)                           o_stall_cnt <= '0;
    else if (run && !i_tile_ready && (o_stall_cnt != 32'hFFFF_FFFF))
                                                 o_stall_cnt <= o_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_df_tile_sequencer.sv
// tb/tb_df_tile_sequencer.sv - scoreboard bench for df_tile_sequencer with loop-nest reference model
module tb_df_tile_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_start;
  logic [11:0] i_x_lim, i_y_lim, i_k_lim, i_c_lim;
  logic [11:0] i_ps_xs, i_if_xs;
  logic [23:0] i_ps_ys, i_ps_ks, i_if_ys, i_if_cs;
  logic [19:0] i_wt_ks;
  logic [15:0] i_wt_cs;
  logic        i_tile_ready;
  logic        o_tile_valid, o_first_c, o_last_c, o_last_tile, o_busy, o_done;
  logic [31:0] o_ps_offs, o_if_offs, o_wt_offs;
`ifdef DF_TILE_SEQ_STALL_CNT_EN
  logic [31:0] o_stall_cnt;
`endif

  df_tile_sequencer #(.OFFS_W(32)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start),
    .i_x_lim(i_x_lim), .i_y_lim(i_y_lim), .i_k_lim(i_k_lim), .i_c_lim(i_c_lim),
    .i_ps_xs(i_ps_xs), .i_ps_ys(i_ps_ys), .i_ps_ks(i_ps_ks),
    .i_if_xs(i_if_xs), .i_if_ys(i_if_ys), .i_if_cs(i_if_cs),
    .i_wt_ks(i_wt_ks), .i_wt_cs(i_wt_cs),
    .o_tile_valid(o_tile_valid), .i_tile_ready(i_tile_ready),
    .o_ps_offs(o_ps_offs), .o_if_offs(o_if_offs), .o_wt_offs(o_wt_offs),
    .o_first_c(o_first_c), .o_last_c(o_last_c), .o_last_tile(o_last_tile),
    .o_busy(o_busy),
`ifdef DF_TILE_SEQ_STALL_CNT_EN
    .o_stall_cnt(o_stall_cnt),
`endif
    .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] ps;
    logic [31:0] ifo;
    logic [31:0] wt;
    logic        fc;
    logic        lc;
    logic        lt;
  } desc_t;

  desc_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    acc_cnt = 0;
  int    stall_seen = 0;
  int    last_acc_cyc = -10;
  bit    done_seen = 0;

  logic [11:0] cfg_xl, cfg_yl, cfg_kl, cfg_cl, cfg_pxs, cfg_ixs;
  logic [23:0] cfg_pys, cfg_pks, cfg_iys, cfg_ics;
  logic [19:0] cfg_wks;
  logic [15:0] cfg_wcs;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Reference: walk the loop nest directly and compute each offset as a sum of products
  task automatic build_model();
    desc_t d;
    exp_q.delete();
    for (int k = 0; k <= int'(cfg_kl); k++)
      for (int y = 0; y <= int'(cfg_yl); y++)
        for (int x = 0; x <= int'(cfg_xl); x++)
          for (int c = 0; c <= int'(cfg_cl); c++) begin
            d.ps  = 32'(k) * 32'(cfg_pks) + 32'(y) * 32'(cfg_pys) + 32'(x) * 32'(cfg_pxs);
            d.ifo = 32'(y) * 32'(cfg_iys) + 32'(x) * 32'(cfg_ixs) + 32'(c) * 32'(cfg_ics);
            d.wt  = 32'(k) * 32'(cfg_wks) + 32'(c) * 32'(cfg_wcs);
            d.fc  = (c == 0);
            d.lc  = (c == int'(cfg_cl));
            d.lt  = (c == int'(cfg_cl)) && (x == int'(cfg_xl)) && (y == int'(cfg_yl)) && (k == int'(cfg_kl));
            exp_q.push_back(d);
          end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every accept, checks hold-stability and done timing
  desc_t held;
  bit    held_v = 0;
  always @(negedge i_clk) begin
    desc_t cur, e;
    if (!i_rstn) begin
      held_v = 0;
    end else begin
      cur = {o_ps_offs, o_if_offs, o_wt_offs, o_first_c, o_last_c, o_last_tile};
      if (held_v) check("hold_stable", {o_tile_valid, cur}, {1'b1, held});
      held_v = 0;
      if (o_tile_valid && i_tile_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_tile: got tile %0d expected none", acc_cnt);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("tile%0d", acc_cnt), cur, e);
        end
        acc_cnt++;
        if (o_last_tile) last_acc_cyc = cyc;
      end else if (o_tile_valid) begin
        held = cur;
        held_v = 1;
        stall_seen++;
      end
      if (o_done) begin
        done_seen = 1;
        check("done_timing", cyc, last_acc_cyc + 1);
        check("done_busy", {o_busy, o_tile_valid}, 2'b10);
      end
    end
  end

  task automatic rand_steps();
    cfg_pxs = 12'($urandom); cfg_pys = 24'($urandom); cfg_pks = 24'($urandom);
    cfg_ixs = 12'($urandom); cfg_iys = 24'($urandom); cfg_ics = 24'($urandom);
    cfg_wks = 20'($urandom); cfg_wcs = 16'($urandom);
  endtask

  task automatic start_layer();
    @(posedge i_clk); #1;
    i_x_lim = cfg_xl; i_y_lim = cfg_yl; i_k_lim = cfg_kl; i_c_lim = cfg_cl;
    i_ps_xs = cfg_pxs; i_ps_ys = cfg_pys; i_ps_ks = cfg_pks;
    i_if_xs = cfg_ixs; i_if_ys = cfg_iys; i_if_cs = cfg_ics;
    i_wt_ks = cfg_wks; i_wt_cs = cfg_wcs;
    i_start = 1; i_tile_ready = 0;
    build_model();
    acc_cnt = 0; stall_seen = 0; done_seen = 0; last_acc_cyc = -10;
    @(negedge i_clk);
    check("pre_start_valid", o_tile_valid, 1'b0);
    @(posedge i_clk); #1;
    i_start = 0;
    check("start_latency", {o_tile_valid, o_busy, o_first_c}, 3'b111);
  endtask

  task automatic run_layer(input bit rnd, input int stall_at, input int stall_len,
                           input int restart_at, input int reset_at, input int exp_stall);
    int left;
    bit restarted;
    left = stall_len;
    restarted = 0;
    for (int n = 0; n < 3000; n++) begin
      if (done_seen) break;
      if (reset_at >= 0 && acc_cnt == reset_at) begin
        i_rstn = 0;
        #1;
        check("reset_outs", {o_tile_valid, o_ps_offs, o_if_offs, o_wt_offs, o_first_c,
                             o_last_c, o_last_tile, o_busy, o_done}, '0);
`ifdef DF_TILE_SEQ_STALL_CNT_EN
        check("reset_stall_cnt", o_stall_cnt, 32'd0);
`endif
        exp_q.delete();
        @(posedge i_clk); #1;
        i_rstn = 1;
        for (int j = 0; j < 3; j++) begin
          @(negedge i_clk);
          check("no_done_after_reset", {o_done, o_busy, o_tile_valid}, 3'b000);
        end
        return;
      end
      if (o_tile_valid && acc_cnt == stall_at && left > 0) begin
        i_tile_ready = 0;
        left--;
      end else if (rnd) begin
        i_tile_ready = ($urandom_range(0, 3) != 0);
      end else begin
        i_tile_ready = 1;
      end
      if (restart_at >= 0 && acc_cnt == restart_at && !restarted) begin
        i_start = 1; i_x_lim = 12'd5; i_y_lim = 12'd3; i_k_lim = 12'd2; i_c_lim = 12'd7;
        restarted = 1;
      end else begin
        i_start = 0;
      end
      @(posedge i_clk); #1;
    end
    i_start = 0;
    if (!done_seen) begin
      total++; bad++;
      $display("FAIL done_timeout: got no o_done expected pulse");
    end
    check("queue_empty", exp_q.size(), 0);
    check("done_one_cycle", {o_done, o_busy, o_tile_valid}, 3'b000);
`ifdef DF_TILE_SEQ_STALL_CNT_EN
    check("stall_cnt", o_stall_cnt, (exp_stall >= 0) ? exp_stall : stall_seen);
`else
    if (exp_stall > 0) check("stall_seen", stall_seen, exp_stall);
`endif
  endtask

  initial begin
    i_rstn = 0; i_start = 0; i_tile_ready = 0;
    i_x_lim = 0; i_y_lim = 0; i_k_lim = 0; i_c_lim = 0;
    i_ps_xs = 0; i_ps_ys = 0; i_ps_ks = 0; i_if_xs = 0; i_if_ys = 0; i_if_cs = 0;
    i_wt_ks = 0; i_wt_cs = 0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("reset_state", {o_tile_valid, o_ps_offs, o_if_offs, o_wt_offs, o_first_c,
                          o_last_c, o_last_tile, o_busy, o_done}, '0);
    @(posedge i_clk); #1;
    i_rstn = 1;

    // single tile layer
    cfg_xl = 0; cfg_yl = 0; cfg_kl = 0; cfg_cl = 0; rand_steps();
    start_layer(); run_layer(0, -1, 0, -1, -1, 0);

    // c only
    cfg_cl = 2; rand_steps(); cfg_ics = 24'h10; cfg_wcs = 16'h4;
    start_layer(); run_layer(0, -1, 0, -1, -1, 0);

    // 2x2x2 psums walk
    cfg_xl = 1; cfg_yl = 1; cfg_kl = 1; cfg_cl = 0; rand_steps();
    cfg_pxs = 12'h1; cfg_pys = 24'h100; cfg_pks = 24'h10000;
    start_layer(); run_layer(0, -1, 0, -1, -1, 0);

    // back-pressure on tile 2
    start_layer(); run_layer(0, 2, 3, -1, -1, 3);

    // start during RUN is ignored
    start_layer(); run_layer(0, -1, 0, 2, -1, 0);

    // reset mid-layer, then full restart
    start_layer(); run_layer(0, -1, 0, -1, 3, 0);
    start_layer(); run_layer(1, -1, 0, -1, -1, -1);

    // randomized layers with random back-pressure
    for (int t = 0; t < 8; t++) begin
      cfg_xl = 12'($urandom_range(0, 2)); cfg_yl = 12'($urandom_range(0, 2));
      cfg_kl = 12'($urandom_range(0, 2)); cfg_cl = 12'($urandom_range(0, 3));
      rand_steps();
      start_layer(); run_layer(1, -1, 0, -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
